// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game sequencing FSM.
// The flow is PRE_GAME -> COUNTDOWN -> IN_GAME <-> PAUSED -> POST_GAME.
// Player HP and exit flags decide when a round ends and who won it.
// All timers advance on the frame tick. Button inputs are levels;
// only their rising edges are acted on.

package game_flow_pkg;
  typedef enum logic [2:0] {
    PRE_GAME  = 3'd0,
    COUNTDOWN = 3'd1,
    IN_GAME   = 3'd2,
    PAUSED    = 3'd3,
    POST_GAME = 3'd4
  } state_t;
endpackage

module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int HP_W            = 4,
  parameter int COUNTDOWN_TICKS = 180,
  parameter int POST_TIMEOUT    = 600,
  parameter int ROUND_W         = 4
) (
  input  logic                                      Clk,
  input  logic                                      Reset_n,
  input  logic                                      tick,
  input  logic                                      game_start,
  input  logic                                      game_pause,
  input  logic                                      game_restart,
  input  logic                                      game_menu,
  input  logic [NUM_PLAYERS-1:0]                    player_exit,
  input  logic [NUM_PLAYERS*HP_W-1:0]               hp,
  output logic [2:0]                                game_state,
  output logic                                      game_reset,
  output logic                                      score_reset,
  output logic                                      freeze,
  output logic [$clog2(COUNTDOWN_TICKS+1)-1:0]      cd_value,
  output logic [3:0]                                winner,
  output logic [ROUND_W-1:0]                        round_count
);

  localparam int CD_W = $clog2(COUNTDOWN_TICKS + 1);
  // Keep the post timer at least one bit wide when the timeout is disabled.
  localparam int PT_W = (POST_TIMEOUT > 0) ? $clog2(POST_TIMEOUT + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COUNTDOWN_TICKS);
  localparam logic [PT_W-1:0] PT_LAST = PT_W'((POST_TIMEOUT > 0) ? POST_TIMEOUT - 1 : 0);

  state_t            state, nxt_state;
  logic [CD_W-1:0]   nxt_cd;
  logic [PT_W-1:0]   post_cnt, nxt_post;
  logic [ROUND_W-1:0] nxt_round;
  logic [3:0]        nxt_winner;
  logic              nxt_game_reset, nxt_score_reset, nxt_freeze;

  logic prev_start, prev_pause, prev_restart, prev_menu;
  logic start_edge, pause_edge, restart_edge, menu_edge;
  logic [3:0] alive_cnt;
  logic [3:0] first_alive;
  logic       end_cond;

  assign game_state = state;

  // Button history. It resets to 1, so a button held through reset makes no edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_start   <= 1'b1;
      prev_pause   <= 1'b1;
      prev_restart <= 1'b1;
      prev_menu    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples values from before the edge.
      prev_start   <= game_start;
      prev_pause   <= game_pause;
      prev_restart <= game_restart;
      prev_menu    <= game_menu;
    end
  end

  assign start_edge   = game_start   & ~prev_start;
  assign pause_edge   = game_pause   & ~prev_pause;
  assign restart_edge = game_restart & ~prev_restart;
  assign menu_edge    = game_menu    & ~prev_menu;

  // Count the live players and find the lowest-index one still standing.
  always_comb begin
    alive_cnt   = '0;
    first_alive = 4'hF;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (!player_exit[i] && hp[i*HP_W +: HP_W] != '0) begin
        alive_cnt   = alive_cnt + 1'b1;
        first_alive = 4'(i);
      end
    end
  end

  assign end_cond = (NUM_PLAYERS >= 2) ? (alive_cnt <= 4'd1) : (alive_cnt == 4'd0);

  // Next-state and datapath decision, followed by the Moore output decode of the next state.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    nxt_state  = state;
    nxt_cd     = cd_value;
    nxt_post   = post_cnt;
    nxt_round  = round_count;
    nxt_winner = winner;

    case (state)
      PRE_GAME: begin
        if (start_edge) begin
          nxt_state = COUNTDOWN;
          nxt_cd    = CD_LOAD;
        end
      end
      COUNTDOWN: begin
        if (menu_edge) begin
          nxt_state = PRE_GAME;
        end else if (tick) begin
          if (cd_value <= CD_W'(1)) begin
            nxt_state = IN_GAME;
            nxt_cd    = '0;
            if (round_count != '1) nxt_round = round_count + 1'b1;
          end else begin
            nxt_cd = cd_value - 1'b1;
          end
        end
      end
      IN_GAME: begin
        if (end_cond) begin
          nxt_state  = POST_GAME;
          nxt_winner = first_alive;
          nxt_post   = '0;
        end else if (pause_edge) begin
          nxt_state = PAUSED;
        end
      end
      PAUSED: begin
        if (menu_edge)       nxt_state = PRE_GAME;
        else if (pause_edge) nxt_state = IN_GAME;
      end
      POST_GAME: begin
        if (restart_edge) begin
          nxt_state = COUNTDOWN;
          nxt_cd    = CD_LOAD;
        end else if (menu_edge) begin
          nxt_state = PRE_GAME;
        end else if (POST_TIMEOUT != 0 && tick) begin
          if (post_cnt == PT_LAST) nxt_state = PRE_GAME;
          else                     nxt_post  = post_cnt + 1'b1;
        end
      end
      default: nxt_state = PRE_GAME;
    endcase

    // Any entry into PRE_GAME, including recovery from an illegal encoding, starts from a clean slate.
    if (nxt_state == PRE_GAME) begin
      nxt_cd     = '0;
      nxt_post   = '0;
      nxt_round  = '0;
      nxt_winner = 4'hF;
    end

    nxt_game_reset  = 1'b1;
    nxt_score_reset = 1'b1;
    nxt_freeze      = 1'b0;
    case (nxt_state)
      IN_GAME:   begin nxt_game_reset = 1'b0; nxt_score_reset = 1'b0; end
      PAUSED:    begin nxt_game_reset = 1'b0; nxt_score_reset = 1'b0; nxt_freeze = 1'b1; end
      POST_GAME: nxt_score_reset = 1'b0;
      default:   ;
    endcase
  end

  // State, timers and registered outputs. Reset takes effect immediately, without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= PRE_GAME;
      cd_value    <= '0;
      post_cnt    <= '0;
      round_count <= '0;
      winner      <= 4'hF;
      game_reset  <= 1'b1;
      score_reset <= 1'b1;
      freeze      <= 1'b0;
    end else begin
      state       <= nxt_state;
      cd_value    <= nxt_cd;
      post_cnt    <= nxt_post;
      round_count <= nxt_round;
      winner      <= nxt_winner;
      game_reset  <= nxt_game_reset;
      score_reset <= nxt_score_reset;
      freeze      <= nxt_freeze;
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with default parameters.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at that same point.
module tb_game_flow_controller;
  import game_flow_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic       tick;
  logic       game_start, game_pause, game_restart, game_menu;
  logic [1:0] player_exit;
  logic [7:0] hp;
  logic [2:0] game_state;
  logic       game_reset, score_reset, freeze;
  logic [7:0] cd_value;
  logic [3:0] winner;
  logic [3:0] round_count;

  int n_checks = 0;
  int n_errors = 0;

  game_flow_controller dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .tick         (tick),
    .game_start   (game_start),
    .game_pause   (game_pause),
    .game_restart (game_restart),
    .game_menu    (game_menu),
    .player_exit  (player_exit),
    .hp           (hp),
    .game_state   (game_state),
    .game_reset   (game_reset),
    .score_reset  (score_reset),
    .freeze       (freeze),
    .cd_value     (cd_value),
    .winner       (winner),
    .round_count  (round_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n      = 1'b0;
    tick         = 1'b0;
    game_start   = 1'b1;
    game_pause   = 1'b0;
    game_restart = 1'b0;
    game_menu    = 1'b0;
    player_exit  = 2'b00;
    hp           = {4'd5, 4'd5};
    repeat (3) step();

    // Reset values
    chk("rst_state", game_state, 0);
    chk("rst_game_reset", game_reset, 1);
    chk("rst_score_reset", score_reset, 1);
    chk("rst_freeze", freeze, 0);
    chk("rst_winner", winner, 4'hF);
    chk("rst_round", round_count, 0);
    chk("rst_cd", cd_value, 0);

    // Start held through reset: no edge
    Reset_n = 1'b1;
    step(); step();
    chk("held_start_no_edge", game_state, 0);
    game_start = 1'b0;
    step();
    chk("released_start", game_state, 0);
    game_start = 1'b1;
    step();
    chk("start_to_cd", game_state, 1);
    chk("cd_loaded", cd_value, 180);
    game_start = 1'b0;

    // Countdown
    do_ticks(179);
    chk("cd_at_1_state", game_state, 1);
    chk("cd_at_1_value", cd_value, 1);
    do_ticks(1);
    chk("cd_done_state", game_state, 2);
    chk("cd_done_value", cd_value, 0);
    chk("round_1", round_count, 1);
    chk("ingame_game_reset", game_reset, 0);
    chk("ingame_score_reset", score_reset, 0);

    // Player 1 dies: player 0 wins
    hp = {4'd0, 4'd5};
    step();
    chk("p1_dead_state", game_state, 4);
    chk("p1_dead_winner", winner, 0);
    chk("post_score_reset", score_reset, 0);
    chk("post_game_reset", game_reset, 1);

    // Restart keeps the winner until the next POST_GAME entry
    hp = {4'd5, 4'd5};
    game_restart = 1'b1;
    step();
    chk("restart_state", game_state, 1);
    chk("restart_cd", cd_value, 180);
    chk("restart_winner_kept", winner, 0);
    game_restart = 1'b0;
    do_ticks(180);
    chk("round2_state", game_state, 2);
    chk("round_2", round_count, 2);

    // Pause; end condition ignored while paused
    game_pause = 1'b1;
    step();
    chk("pause_state", game_state, 3);
    chk("pause_freeze", freeze, 1);
    chk("pause_game_reset", game_reset, 0);
    game_pause = 1'b0;
    hp = {4'd5, 4'd0};
    step(); step();
    chk("paused_ignores_end", game_state, 3);
    game_pause = 1'b1;
    step();
    chk("resume_state", game_state, 2);
    chk("resume_freeze", freeze, 0);
    game_pause = 1'b0;
    step();
    chk("resume_end_state", game_state, 4);
    chk("resume_end_winner", winner, 1);

    // Both exit in the same cycle as a pause edge: end wins, no winner
    hp = {4'd5, 4'd5};
    game_restart = 1'b1;
    step();
    game_restart = 1'b0;
    do_ticks(180);
    chk("round3_state", game_state, 2);
    chk("round_3", round_count, 3);
    player_exit = 2'b11;
    game_pause  = 1'b1;
    step();
    chk("both_exit_state", game_state, 4);
    chk("both_exit_winner", winner, 4'hF);
    game_pause  = 1'b0;
    player_exit = 2'b00;
    step();

    // Post-game timeout of exactly 600 ticks
    do_ticks(599);
    chk("post_599", game_state, 4);
    do_ticks(1);
    chk("post_600_state", game_state, 0);
    chk("post_600_round", round_count, 0);
    chk("post_600_winner", winner, 4'hF);
    chk("pre_score_reset", score_reset, 1);

    // Restart and menu together: restart wins
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    do_ticks(180);
    chk("round1b_state", game_state, 2);
    chk("round1b_count", round_count, 1);
    hp = {4'd0, 4'd5};
    step();
    chk("post_b_state", game_state, 4);
    hp = {4'd5, 4'd5};
    game_restart = 1'b1;
    game_menu    = 1'b1;
    step();
    chk("restart_over_menu", game_state, 1);
    chk("restart_over_menu_cd", cd_value, 180);
    game_restart = 1'b0;
    game_menu    = 1'b0;
    step();

    // Menu during countdown returns to PRE_GAME and clears the round counter
    game_menu = 1'b1;
    step();
    chk("cd_menu_state", game_state, 0);
    chk("cd_menu_round", round_count, 0);
    chk("cd_menu_winner", winner, 4'hF);
    game_menu = 1'b0;
    step();

    // Asynchronous reset mid-game
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    do_ticks(180);
    chk("async_pre_state", game_state, 2);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_state", game_state, 0);
    chk("async_game_reset", game_reset, 1);
    chk("async_score_reset", score_reset, 1);
    chk("async_round", round_count, 0);
    step();
    Reset_n = 1'b1;
    step();

    // Illegal encoding recovers to PRE_GAME
    force dut.state = state_t'(3'd7);
    #1;
    release dut.state;
    step();
    chk("illegal_recover", game_state, 0);
    chk("illegal_recover_reset", game_reset, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Top-level game sequencing FSM, generalised to a parametrised player count, with start countdown, pause/resume, winner detection and an optional post-game auto-return to the menu. It consumes per-player HP and exit flags plus a frame tick, and drives game_state, game_reset, score_reset, freeze and round/winner outputs to the draw, sprite and score logic.

Parameters:
NUM_PLAYERS, 2, number of player channels (1..8)
HP_W, 4, width of each player's HP field
COUNTDOWN_TICKS, 180, ticks spent in COUNTDOWN before play (>=1)
POST_TIMEOUT, 600, ticks in POST_GAME before auto-return to PRE_GAME; 0 disables
ROUND_W, 4, width of round counter

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle pulse per frame; timebase for all timers
game_start  in  1  level button; rising edge used
game_pause  in  1  level button; rising edge toggles pause
game_restart  in  1  level button; rising edge used
game_menu  in  1  level button; rising edge used
player_exit  in  NUM_PLAYERS  bit i = player i eliminated
hp  in  NUM_PLAYERS*HP_W  packed HP, player i at [i*HP_W +: HP_W]
game_state  out  3  0 PRE_GAME, 1 COUNTDOWN, 2 IN_GAME, 3 PAUSED, 4 POST_GAME
game_reset  out  1  hold game objects in reset
score_reset  out  1  clear scores
freeze  out  1  game objects hold position (PAUSED)
cd_value  out  $clog2(COUNTDOWN_TICKS+1)  remaining countdown ticks
winner  out  4  winning player index; 4'hF = no winner
round_count  out  ROUND_W  rounds started since last PRE_GAME

Behaviour:
- Reset_n low: state PRE_GAME, timers 0, winner 4'hF, round_count 0, button history regs all 1 (a button held through reset produces no edge).
- Button edge = level & ~prev, prev registered every Clk. Edges are single-cycle.
- Alive[i] = !player_exit[i] && hp_i != 0. End condition: NUM_PLAYERS>=2 -> alive count <=1; NUM_PLAYERS==1 -> alive count ==0.
- Transitions (registered; new state visible one Clk after the edge/condition):
  PRE_GAME: start edge -> COUNTDOWN, load cd_value = COUNTDOWN_TICKS.
  COUNTDOWN: each tick decrements cd_value; a tick when cd_value==1 -> IN_GAME, cd_value=0, round_count += 1 (saturating at all ones). Menu edge -> PRE_GAME.
  IN_GAME: end condition -> POST_GAME, latch winner = lowest-index alive player, else 4'hF. Pause edge -> PAUSED. End condition beats pause in the same cycle.
  PAUSED: pause edge -> IN_GAME; menu edge -> PRE_GAME (menu wins). End condition ignored while paused.
  POST_GAME: restart edge -> COUNTDOWN (reload cd_value, winner kept until next POST entry); menu edge -> PRE_GAME; if POST_TIMEOUT!=0, POST_TIMEOUT ticks elapsed -> PRE_GAME. Priority restart > menu > timeout. Post timer cleared on entry.
- Entering PRE_GAME clears round_count and sets winner 4'hF.
- Moore outputs decoded from the state register:
  PRE_GAME: game_reset 1, score_reset 1, freeze 0.
  COUNTDOWN: game_reset 1, score_reset 1, freeze 0.
  IN_GAME: game_reset 0, score_reset 0, freeze 0.
  PAUSED: game_reset 0, score_reset 0, freeze 1.
  POST_GAME: game_reset 1, score_reset 0 (scores hold for display), freeze 0.
- Illegal state encodings recover to PRE_GAME on the next Clk.
- Async reset asserted mid-game forces PRE_GAME immediately, without waiting for Clk.

Test Plan:
- Reset with game_start held high, then release and re-press -> no transition until the second rising edge. Then state 1 with cd_value=180; 180 ticks later state 2 and round_count=1.
- NUM_PLAYERS=2, IN_GAME, player 1 hp drops to 0 -> next Clk state 4, winner=0, score_reset=0, game_reset=1.
- IN_GAME: pause edge -> state 3, freeze=1. Player 0 hp set to 0 while paused -> stays 3. Pause edge -> state 2, then state 4 next Clk with winner=1.
- Both players exit in the same cycle as a pause edge -> state 4, winner=4'hF.
- POST_GAME with POST_TIMEOUT=600 -> exactly 600 ticks later state 0, round_count=0. Restart and menu edges in the same cycle -> state 1.
- Assert Reset_n low between Clk edges during IN_GAME -> outputs return to reset values asynchronously. Drive an illegal state via force -> PRE_GAME on the next Clk.
